// File: rtl/song_pkg.sv
// ============================================================================
// song_pkg : shared types, field widths and pitch period table for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package song_pkg;

  localparam int PITCH_W = 4;
  localparam int DUR_W   = 3;

  typedef struct packed {
    logic [PITCH_W-1:0] pitch;
    logic [DUR_W-1:0]   dur;
  } rom_entry_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Tone period in 50 MHz clk cycles; pitch 0 is a rest and yields 0.
  function automatic logic [31:0] pitch_period(input logic [PITCH_W-1:0] pitch);
    logic [31:0] p;
    case (pitch)
      4'd1:    p = 32'd191110;  // C4
      4'd2:    p = 32'd170265;  // D4
      4'd3:    p = 32'd151685;  // E4
      4'd4:    p = 32'd143172;  // F4
      4'd5:    p = 32'd127551;  // G4
      4'd6:    p = 32'd113636;  // A4
      4'd7:    p = 32'd101238;  // B4
      4'd8:    p = 32'd95556;   // C5
      4'd9:    p = 32'd85131;   // D5
      4'd10:   p = 32'd75843;   // E5
      4'd11:   p = 32'd71586;   // F5
      4'd12:   p = 32'd63776;   // G5
      4'd13:   p = 32'd56818;   // A5
      4'd14:   p = 32'd50619;   // B5
      4'd15:   p = 32'd47778;   // C6
      default: p = 32'd0;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/song_rom.sv
// ============================================================================
// song_rom : melody ROM of {pitch, dur} entries, registered read (1-cycle latency)
// Rev 1.0
// ============================================================================
`default_nettype none

module song_rom
  import song_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output rom_entry_t        q
);

  function automatic rom_entry_t ent(input int p, input int d);
    return '{pitch: PITCH_W'(p), dur: DUR_W'(d)};
  endfunction

  function automatic rom_entry_t melody(input logic [ADDR_W-1:0] a);
    rom_entry_t e;
    case (32'(a))
      0:  e = ent(6, 0);   1:  e = ent(0, 1);   2:  e = ent(8, 2);   3:  e = ent(1, 0);
      4:  e = ent(1, 0);   5:  e = ent(1, 0);   6:  e = ent(5, 0);   7:  e = ent(5, 0);
      8:  e = ent(6, 0);   9:  e = ent(6, 0);   10: e = ent(5, 1);   11: e = ent(4, 0);
      12: e = ent(4, 0);   13: e = ent(3, 0);   14: e = ent(3, 0);   15: e = ent(2, 0);
      16: e = ent(2, 0);   17: e = ent(1, 1);   18: e = ent(0, 0);   19: e = ent(5, 0);
      20: e = ent(5, 0);   21: e = ent(4, 0);   22: e = ent(4, 0);   23: e = ent(3, 0);
      24: e = ent(3, 0);   25: e = ent(2, 1);   26: e = ent(8, 0);   27: e = ent(7, 0);
      28: e = ent(6, 0);   29: e = ent(5, 0);   30: e = ent(1, 3);   31: e = ent(0, 1);
      default: e = ent(0, 0);
    endcase
    return e;
  endfunction

  always_ff @(posedge clk) begin
    q <= melody(addr);
  end

endmodule

`default_nettype wire

// File: rtl/song_sequencer.sv
// ============================================================================
// song_sequencer : steps the melody ROM and drives cnt_acc/rest for the tone generator.
// Optional ARTIC_GAP_EN: silence the last GAP_CYC cycles of each note (staccato).
// Rev 1.0
// ============================================================================
`default_nettype none

module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned TICK_CNT = 12500000,
  parameter int unsigned SONG_LEN = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned GAP_CYC  = 1250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              loop_en,
  output logic [31:0]       cnt_acc,
  output logic              rest,
  output logic              note_start,
  output logic              song_done,
  output logic [ADDR_W-1:0] addr
);

  localparam int TICK_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CNT - 1);
  localparam logic [TICK_W-1:0] GAP_START = TICK_W'(TICK_CNT - GAP_CYC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t             state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [31:0]        note_per;
  logic               note_rest;
  rom_entry_t         rom_q;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               tick_hit;
  logic               last_entry;
  logic               note_end;
  logic [31:0]        load_per;
  logic               load_rest;

  function automatic logic in_gap(input logic [DUR_W-1:0] d, input logic [TICK_W-1:0] t);
    return (d == '0) && (t >= GAP_START);
  endfunction

  assign tick_hit   = (tick_cnt == TICK_LAST);
  assign last_entry = (addr == ADDR_LAST);
  assign note_end   = (state == S_HOLD) && play && tick_hit && (dur_cnt == '0);
  assign load_per   = pitch_period(rom_q.pitch);
  assign load_rest  = (rom_q.pitch == '0);

  // The ROM is fed the address being registered this edge so its output is valid in LOAD.
  always_comb begin
    addr_nxt = addr;
    if (note_end) begin
      if (!last_entry)  addr_nxt = addr + ADDR_W'(1);
      else if (loop_en) addr_nxt = '0;
    end else if (state == S_DONE && !play) begin
      addr_nxt = '0;
    end
  end

  song_rom #(.ADDR_W(ADDR_W)) u_rom (
    .clk  (clk),
    .addr (addr_nxt),
    .q    (rom_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      cnt_acc    <= '0;
      rest       <= 1'b1;
      note_start <= 1'b0;
      song_done  <= 1'b0;
      tick_cnt   <= '0;
      dur_cnt    <= '0;
      note_per   <= '0;
      note_rest  <= 1'b1;
    end else begin
      note_start <= 1'b0;
      song_done  <= 1'b0;
      addr       <= addr_nxt;
      case (state)
        S_IDLE: begin
          cnt_acc <= '0;
          rest    <= 1'b1;
          if (play) state <= S_LOAD;
        end
        S_LOAD: begin
          tick_cnt  <= '0;
          dur_cnt   <= rom_q.dur;
          note_per  <= load_per;
          note_rest <= load_rest;
          if (play) begin
            state      <= S_HOLD;
            cnt_acc    <= load_per;
            rest       <= load_rest;
            note_start <= 1'b1;
          end else begin
            state <= S_PAUSE;
          end
        end
        S_HOLD: begin
          if (!play) begin
            // A pending tick is kept so it fires on resume.
            state   <= S_PAUSE;
            cnt_acc <= '0;
            rest    <= 1'b1;
            if (!tick_hit) tick_cnt <= tick_cnt + TICK_W'(1);
          end else if (tick_hit) begin
            tick_cnt <= '0;
            if (dur_cnt != '0) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end else begin
              cnt_acc <= '0;
              rest    <= 1'b1;
              if (!last_entry || loop_en) begin
                state <= S_LOAD;
              end else begin
                state     <= S_DONE;
                song_done <= 1'b1;
              end
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
`ifdef ARTIC_GAP_EN
            if (in_gap(dur_cnt, tick_cnt + TICK_W'(1))) begin
              cnt_acc <= '0;
              rest    <= 1'b1;
            end
`endif
          end
        end
        S_PAUSE: begin
          cnt_acc <= '0;
          rest    <= 1'b1;
          if (play) begin
            state   <= S_HOLD;
            cnt_acc <= note_per;
            rest    <= note_rest;
`ifdef ARTIC_GAP_EN
            if (in_gap(dur_cnt, tick_cnt)) begin
              cnt_acc <= '0;
              rest    <= 1'b1;
            end
`endif
          end
        end
        S_DONE: begin
          cnt_acc <= '0;
          rest    <= 1'b1;
          if (!play) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_song_sequencer.sv
// ============================================================================
// tb_song_sequencer : directed self-checking bench (TICK_CNT=10, SONG_LEN=4, GAP_CYC=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_song_sequencer;

  localparam logic [31:0] A4 = 32'd113636;
  localparam logic [31:0] C5 = 32'd95556;
  localparam logic [31:0] C4 = 32'd191110;
`ifdef ARTIC_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0;
  logic        loop_en = 1'b0;
  logic [31:0] cnt_acc;
  logic        rest;
  logic        note_start;
  logic        song_done;
  logic [4:0]  addr;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  song_sequencer #(.TICK_CNT(10), .SONG_LEN(4), .ADDR_W(5), .GAP_CYC(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .loop_en    (loop_en),
    .cnt_acc    (cnt_acc),
    .rest       (rest),
    .note_start (note_start),
    .song_done  (song_done),
    .addr       (addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the DUT in its first LOAD cycle with cyc == 1.
  task automatic restart(input logic lp);
    rst = 1'b1; play = 1'b0; loop_en = lp;
    step(); step();
    rst = 1'b0; play = 1'b1; cyc = 0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; play = 1'b0;
    step(); step();
    checks++;
    if ({cnt_acc, rest, note_start, song_done, addr} !== {32'd0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h",
               {cnt_acc, rest, note_start, song_done, addr}, {32'd0, 1'b1, 1'b0, 1'b0, 5'd0});
    end
  endtask

  task automatic test_first_notes();
    restart(1'b0);
    while (cyc <= 13) begin
      if (cyc == 1) begin
        checks++;
        if ({cnt_acc, rest, note_start} !== {32'd0, 1'b1, 1'b0}) begin
          fails++; $display("FAIL load_cycle: got %0d/%b/%b expected 0/1/0", cnt_acc, rest, note_start);
        end
      end
      if (cyc == 2) begin
        checks++;
        if ({cnt_acc, rest, note_start, addr} !== {A4, 1'b0, 1'b1, 5'd0}) begin
          fails++; $display("FAIL first_note: got %0d/%b/%b/%0d expected %0d/0/1/0", cnt_acc, rest, note_start, addr, A4);
        end
      end
      if (cyc == 3 || cyc == 12) begin
        checks++;
        if (note_start !== 1'b0) begin
          fails++; $display("FAIL note_start_width cyc%0d: got %b expected 0", cyc, note_start);
        end
      end
      if (cyc == 13) begin
        checks++;
        if ({cnt_acc, rest, note_start, addr} !== {32'd0, 1'b1, 1'b1, 5'd1}) begin
          fails++; $display("FAIL rest_note: got %0d/%b/%b/%0d expected 0/1/1/1", cnt_acc, rest, note_start, addr);
        end
      end
      step();
    end
  endtask

  task automatic test_artic_gap();
    restart(1'b0);
    while (cyc <= 63) begin
      if (cyc == 8 || cyc == 60) begin
        checks++;
        if ({cnt_acc, rest} !== {(cyc == 8) ? A4 : C5, 1'b0}) begin
          fails++; $display("FAIL pre_gap cyc%0d: got %0d/%b expected note/0", cyc, cnt_acc, rest);
        end
      end
      if ((cyc >= 9 && cyc <= 11) || cyc >= 61) begin
        checks++;
        if ({cnt_acc, rest} !== (GAP ? {32'd0, 1'b1} : {(cyc <= 11) ? A4 : C5, 1'b0})) begin
          fails++; $display("FAIL gap_window cyc%0d: got %0d/%b", cyc, cnt_acc, rest);
        end
      end
      step();
    end
  endtask

  task automatic test_full_song();
    int pulses = 0;
    restart(1'b0);
    while (cyc <= 80) begin
      if (song_done === 1'b1) pulses++;
      if (cyc == 65) begin
        checks++;
        if ({cnt_acc, note_start, addr} !== {C4, 1'b1, 5'd3}) begin
          fails++; $display("FAIL last_note: got %0d/%b/%0d expected %0d/1/3", cnt_acc, note_start, addr, C4);
        end
      end
      if (cyc == 75) begin
        checks++;
        if (song_done !== 1'b1) begin
          fails++; $display("FAIL song_done_time: got %b expected 1", song_done);
        end
      end
      if (cyc == 80) begin
        checks++;
        if ({cnt_acc, rest, song_done, addr} !== {32'd0, 1'b1, 1'b0, 5'd3}) begin
          fails++; $display("FAIL done_hold: got %0d/%b/%b/%0d expected 0/1/0/3", cnt_acc, rest, song_done, addr);
        end
      end
      step();
    end
    checks++;
    if (pulses != 1) begin
      fails++; $display("FAIL song_done_count: got %0d expected 1", pulses);
    end
    play = 1'b0;
    step();
    checks++;
    if ({cnt_acc, rest, addr} !== {32'd0, 1'b1, 5'd0}) begin
      fails++; $display("FAIL done_to_idle: got %0d/%b/%0d expected 0/1/0", cnt_acc, rest, addr);
    end
  endtask

  task automatic test_loop();
    int pulses = 0;
    restart(1'b1);
    while (cyc <= 80) begin
      if (song_done === 1'b1) pulses++;
      if (cyc == 75) begin
        checks++;
        if ({note_start, addr} !== {1'b0, 5'd0}) begin
          fails++; $display("FAIL loop_wrap_load: got %b/%0d expected 0/0", note_start, addr);
        end
      end
      if (cyc == 76) begin
        checks++;
        if ({cnt_acc, rest, note_start, addr} !== {A4, 1'b0, 1'b1, 5'd0}) begin
          fails++; $display("FAIL loop_restart: got %0d/%b/%b/%0d expected %0d/0/1/0", cnt_acc, rest, note_start, addr, A4);
        end
      end
      step();
    end
    checks++;
    if (pulses != 0) begin
      fails++; $display("FAIL loop_song_done: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_pause();
    restart(1'b0);
    while (cyc <= 70) begin
      if (cyc >= 41 && cyc <= 45) begin
        checks++;
        if ({cnt_acc, rest, addr} !== {32'd0, 1'b1, 5'd2}) begin
          fails++; $display("FAIL pause_silent cyc%0d: got %0d/%b/%0d expected 0/1/2", cyc, cnt_acc, rest, addr);
        end
      end
      if (cyc == 46) begin
        checks++;
        if ({cnt_acc, rest, note_start} !== {C5, 1'b0, 1'b0}) begin
          fails++; $display("FAIL pause_resume: got %0d/%b/%b expected %0d/0/0", cnt_acc, rest, note_start, C5);
        end
      end
      if (cyc == 65) begin
        checks++;
        if (note_start !== 1'b0) begin
          fails++; $display("FAIL pause_no_early_end: got %b expected 0", note_start);
        end
      end
      if (cyc == 70) begin
        checks++;
        if ({cnt_acc, note_start, addr} !== {C4, 1'b1, 5'd3}) begin
          fails++; $display("FAIL pause_shifted_end: got %0d/%b/%0d expected %0d/1/3", cnt_acc, note_start, addr, C4);
        end
      end
      if (cyc == 40) play = 1'b0;
      if (cyc == 45) play = 1'b1;
      step();
    end
  endtask

  task automatic test_pause_on_tick();
    restart(1'b0);
    while (cyc <= 16) begin
      if (cyc == 12) begin
        checks++;
        if ({cnt_acc, rest, addr} !== {32'd0, 1'b1, 5'd0}) begin
          fails++; $display("FAIL tick_pause: got %0d/%b/%0d expected 0/1/0", cnt_acc, rest, addr);
        end
      end
      if (cyc == 14) begin
        checks++;
        if ({cnt_acc, note_start, addr} !== {GAP ? 32'd0 : A4, 1'b0, 5'd0}) begin
          fails++; $display("FAIL tick_resume: got %0d/%b/%0d", cnt_acc, note_start, addr);
        end
      end
      if (cyc == 16) begin
        checks++;
        if ({note_start, addr} !== {1'b1, 5'd1}) begin
          fails++; $display("FAIL tick_consumed_late: got %b/%0d expected 1/1", note_start, addr);
        end
      end
      if (cyc == 11) play = 1'b0;
      if (cyc == 13) play = 1'b1;
      step();
    end
  endtask

  task automatic test_reset_mid_note();
    restart(1'b0);
    while (cyc < 20) step();
    rst = 1'b1;
    step();
    checks++;
    if ({cnt_acc, rest, note_start, song_done, addr} !== {32'd0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL mid_note_reset: got %h expected %h",
               {cnt_acc, rest, note_start, song_done, addr}, {32'd0, 1'b1, 1'b0, 1'b0, 5'd0});
    end
    rst = 1'b0;
    step(); step();
    checks++;
    if ({cnt_acc, note_start, addr} !== {A4, 1'b1, 5'd0}) begin
      fails++; $display("FAIL restart_after_reset: got %0d/%b/%0d expected %0d/1/0", cnt_acc, note_start, addr, A4);
    end
  endtask

  initial begin
    test_reset();
    test_first_notes();
    test_artic_gap();
    test_full_song();
    test_loop();
    test_pause();
    test_pause_on_tick();
    test_reset_mid_note();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
